object_scanline_feeder: RTL and testbench

Upstream sequencer for the object scanline buffer. On each line request it clears the buffer for the new line, then walks object memory (OBM) from highest to lowest index. For every object that intersects the line, it holds the object stable and streams its 2-bit lightness pixels from pattern memory into the buffer's load port. Lowest-index objects are written last, so they win overlaps.

---
 rtl/object_scanline_feeder.sv | 192 +++++++++++++++++++
 tb/tb_object_scanline_feeder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/object_scanline_feeder.sv
// Object scanline feeder: clears the scanline buffer, then walks OBM from the highest
// index down and streams the pattern pixels of every object that covers the line.

package mapache64;
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [4:0] pattern;
        logic [3:0] color;
        logic       hflip;
        logic       vflip;
    } obm_object_t;
endpackage

module object_scanline_feeder #(
    parameter int unsigned NUM_OBJECTS = 64,
    parameter int unsigned OBM_AW      = $clog2(NUM_OBJECTS)
) (
    input  logic                  gpu_clk,
    input  logic                  rst,
    input  logic                  line_start_i,
    input  logic [7:0]            line_y_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [OBM_AW-1:0]     obm_addr_o,
    input  mapache64::obm_object_t obm_data_i,
    output logic [7:0]            pattern_addr_o,
    input  logic [15:0]           pattern_data_i,
    input  logic                  os_ready_i,
    output logic                  os_clear_start_o,
    output logic [7:0]            os_new_y_o,
    output logic                  os_load_start_o,
    output mapache64::obm_object_t os_load_object_o,
    input  logic [2:0]            os_load_intx_i,
    input  logic [2:0]            os_load_inty_i,
    output logic [1:0]            os_load_lightness_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_CLEAR_WAIT,
        S_FETCH,
        S_CHECK,
        S_LOAD,
        S_LOAD_WAIT,
        S_DONE
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [7:0]             r_y, w_y_nxt;
    logic [OBM_AW-1:0]      r_idx, w_idx_nxt;
    mapache64::obm_object_t r_obj, w_obj_nxt;
    logic                   r_skip, w_skip_nxt;
    logic                   r_clear_start, w_clear_start_nxt;
    logic                   r_load_start, w_load_start_nxt;
    logic [7:0]             r_new_y, w_new_y_nxt;

    logic [8:0]  w_line9;
    logic [8:0]  w_top9;
    logic        w_hit;
    logic        w_last;
    logic [2:0]  w_row;
    logic [2:0]  w_px;
    logic [15:0] w_shifted;

    // 9-bit compare so objects near the bottom never wrap onto the top lines
    assign w_line9 = {1'b0, r_y};
    assign w_top9  = {1'b0, obm_data_i.y};
    assign w_hit   = (w_line9 >= w_top9) && (w_line9 <= (w_top9 + 9'd7));
    assign w_last  = (r_idx == '0);

    always_comb begin
        w_state_nxt       = r_state;
        w_y_nxt           = r_y;
        w_idx_nxt         = r_idx;
        w_obj_nxt         = r_obj;
        w_skip_nxt        = r_skip;
        w_clear_start_nxt = 1'b0;
        w_load_start_nxt  = 1'b0;
        w_new_y_nxt       = r_new_y;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_IDLE;
            end
            S_CLEAR: begin
                if (os_ready_i) begin
                    w_clear_start_nxt = 1'b1;
                    w_new_y_nxt       = r_y;
                    w_skip_nxt        = 1'b1;
                    w_state_nxt       = S_CLEAR_WAIT;
                end
            end
            S_CLEAR_WAIT: begin
                if (r_skip) begin
                    w_skip_nxt = 1'b0;
                end else if (os_ready_i) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                w_obj_nxt = obm_data_i;
                if (w_hit) begin
                    w_state_nxt = S_LOAD;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt   = r_idx - OBM_AW'(1);
                    w_state_nxt = S_FETCH;
                end
            end
            S_LOAD: begin
                if (os_ready_i) begin
                    w_load_start_nxt = 1'b1;
                    w_skip_nxt       = 1'b1;
                    w_state_nxt      = S_LOAD_WAIT;
                end
            end
            S_LOAD_WAIT: begin
                if (r_skip) begin
                    w_skip_nxt = 1'b0;
                end else if (os_ready_i) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = r_idx - OBM_AW'(1);
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A new line request wins from any state; in-flight buffer work drains on its own
        if (line_start_i) begin
            w_y_nxt           = line_y_i;
            w_idx_nxt         = OBM_AW'(NUM_OBJECTS - 1);
            w_skip_nxt        = 1'b0;
            w_clear_start_nxt = 1'b0;
            w_load_start_nxt  = 1'b0;
            w_state_nxt       = S_CLEAR;
        end
    end

    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_y           <= '0;
            r_idx         <= '0;
            r_obj         <= '0;
            r_skip        <= 1'b0;
            r_clear_start <= 1'b0;
            r_load_start  <= 1'b0;
            r_new_y       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_y           <= w_y_nxt;
            r_idx         <= w_idx_nxt;
            r_obj         <= w_obj_nxt;
            r_skip        <= w_skip_nxt;
            r_clear_start <= w_clear_start_nxt;
            r_load_start  <= w_load_start_nxt;
            r_new_y       <= w_new_y_nxt;
        end
    end

    // Flips are applied here so the buffer can always walk rows/pixels in screen order
    assign w_row     = r_obj.vflip ? (3'd7 - os_load_inty_i) : os_load_inty_i;
    assign w_px      = r_obj.hflip ? (3'd7 - os_load_intx_i) : os_load_intx_i;
    assign w_shifted = pattern_data_i << {w_px, 1'b0};

    assign pattern_addr_o      = {r_obj.pattern, w_row};
    assign os_load_lightness_o = w_shifted[15:14];

    assign busy_o           = (r_state != S_IDLE);
    assign done_o           = (r_state == S_DONE);
    assign obm_addr_o       = r_idx;
    assign os_clear_start_o = r_clear_start;
    assign os_load_start_o  = r_load_start;
    assign os_new_y_o       = r_new_y;
    assign os_load_object_o = r_obj;

endmodule

// File: tb/tb_object_scanline_feeder.sv
// Bench for object_scanline_feeder: OBM/pattern memories, a behavioural scanline buffer,
// and a line-level reference model of the final buffer contents and load order.

module tb_object_scanline_feeder;
    import mapache64::*;

    localparam int unsigned N         = 16;
    localparam int unsigned AW        = $clog2(N);
    localparam int          CLEAR_CYC = 256;

    logic          gpu_clk = 1'b0;
    logic          rst;
    logic          line_start_i;
    logic [7:0]    line_y_i;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] obm_addr_o;
    obm_object_t   obm_data_i;
    logic [7:0]    pattern_addr_o;
    logic [15:0]   pattern_data_i;
    logic          os_ready_i;
    logic          os_clear_start_o;
    logic [7:0]    os_new_y_o;
    logic          os_load_start_o;
    obm_object_t   os_load_object_o;
    logic [2:0]    os_load_intx_i;
    logic [2:0]    os_load_inty_i;
    logic [1:0]    os_load_lightness_o;

    object_scanline_feeder #(.NUM_OBJECTS(N), .OBM_AW(AW)) dut (
        .gpu_clk             (gpu_clk),
        .rst                 (rst),
        .line_start_i        (line_start_i),
        .line_y_i            (line_y_i),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .obm_addr_o          (obm_addr_o),
        .obm_data_i          (obm_data_i),
        .pattern_addr_o      (pattern_addr_o),
        .pattern_data_i      (pattern_data_i),
        .os_ready_i          (os_ready_i),
        .os_clear_start_o    (os_clear_start_o),
        .os_new_y_o          (os_new_y_o),
        .os_load_start_o     (os_load_start_o),
        .os_load_object_o    (os_load_object_o),
        .os_load_intx_i      (os_load_intx_i),
        .os_load_inty_i      (os_load_inty_i),
        .os_load_lightness_o (os_load_lightness_o)
    );

    always #5 gpu_clk = ~gpu_clk;

    obm_object_t obm [N];
    logic [15:0] patmem [256];
    int          cyc = 0;

    always @(posedge gpu_clk) begin
        obm_data_i <= obm[obm_addr_o];
        cyc        <= cyc + 1;
    end
    assign pattern_data_i = patmem[pattern_addr_o];

    // Pulse monitor (counts high cycles, so a stretched pulse shows up as an extra count)
    int done_cnt = 0;
    int clr_hi   = 0;
    int ld_hi    = 0;
    always @(negedge gpu_clk) begin
        if (done_o === 1'b1) done_cnt++;
        if (os_clear_start_o === 1'b1) clr_hi++;
        if (os_load_start_o === 1'b1) ld_hi++;
    end

    // Behavioural scanline buffer
    logic [1:0]  linebuf [256];
    int          clear_cnt = 0;
    int          load_cnt  = 0;
    int          ready_cyc = 0;
    logic [7:0]  clear_y   = 8'd0;
    logic [7:0]  first_paddr;
    int          obj_unstable = 0;
    obm_object_t load_log [$];

    initial begin
        obm_object_t bobj;
        logic [1:0]  lt;
        os_ready_i     = 1'b1;
        os_load_intx_i = 3'd0;
        os_load_inty_i = 3'd0;
        first_paddr    = 8'd0;
        for (int p = 0; p < 256; p++) linebuf[p] = 2'd0;
        forever begin
            @(negedge gpu_clk);
            if (os_clear_start_o === 1'b1) begin
                clear_cnt++;
                clear_y    = os_new_y_o;
                os_ready_i = 1'b0;
                for (int p = 0; p < 256; p++) linebuf[p] = 2'd0;
                repeat (CLEAR_CYC) @(negedge gpu_clk);
                os_ready_i = 1'b1;
                ready_cyc  = cyc;
            end else if (os_load_start_o === 1'b1) begin
                bobj = os_load_object_o;
                load_cnt++;
                load_log.push_back(bobj);
                os_ready_i     = 1'b0;
                os_load_inty_i = 3'(clear_y - bobj.y);
                for (int k = 0; k < 8; k++) begin
                    os_load_intx_i = 3'(k);
                    @(negedge gpu_clk);
                    if (k == 0) first_paddr = pattern_addr_o;
                    if (os_load_object_o !== bobj) obj_unstable++;
                    lt = os_load_lightness_o;
                    if (lt != 2'd0 && int'(bobj.x) + k < 256) linebuf[int'(bobj.x) + k] = lt;
                end
                os_ready_i     = 1'b1;
                os_load_intx_i = 3'd0;
                os_load_inty_i = 3'd0;
            end
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: paint every covering object from highest to lowest index
    logic [1:0]  exp_buf [256];
    obm_object_t exp_log [$];

    task automatic build_expected(input int line);
        int ry, r, c, v, prow;
        obm_object_t o;
        for (int p = 0; p < 256; p++) exp_buf[p] = 2'd0;
        exp_log.delete();
        for (int i = N - 1; i >= 0; i--) begin
            o = obm[i];
            if (line >= int'(o.y) && line <= int'(o.y) + 7) begin
                exp_log.push_back(o);
                ry   = line - int'(o.y);
                r    = o.vflip ? 7 - ry : ry;
                prow = int'(patmem[int'(o.pattern) * 8 + r]);
                for (int k = 0; k < 8; k++) begin
                    c = o.hflip ? 7 - k : k;
                    v = (prow >> (14 - 2 * c)) & 3;
                    if (v != 0 && int'(o.x) + k < 256) exp_buf[int'(o.x) + k] = 2'(v);
                end
            end
        end
    endtask

    int lb;

    task automatic run_line(input logic [7:0] y, input bit check_timing);
        int b_clr, b_ld, b_done, b_chi, b_lhi, b_uns, to, done_c, n, bad;
        build_expected(int'(y));
        b_clr = clear_cnt; b_ld = load_cnt; b_done = done_cnt;
        b_chi = clr_hi; b_lhi = ld_hi; b_uns = obj_unstable;
        lb = load_log.size();
        @(negedge gpu_clk);
        line_y_i     = y;
        line_start_i = 1'b1;
        @(negedge gpu_clk);
        line_start_i = 1'b0;
        chk("busy_rise", busy_o, 1);
        to = 0;
        while (done_o !== 1'b1 && to < 20000) begin
            @(negedge gpu_clk);
            to++;
        end
        done_c = cyc;
        chk("done_seen", done_o, 1);
        if (check_timing) chk("done_latency", done_c - ready_cyc, 2 * N + 1);
        @(negedge gpu_clk);
        chk("busy_fall", busy_o, 0);
        repeat (2) @(negedge gpu_clk);
        chk("clear_count", clear_cnt - b_clr, 1);
        chk("clear_pulse_width", clr_hi - b_chi, 1);
        chk("clear_y", clear_y, y);
        chk("done_count", done_cnt - b_done, 1);
        n = load_cnt - b_ld;
        chk("load_count", n, exp_log.size());
        chk("load_pulse_width", ld_hi - b_lhi, exp_log.size());
        bad = 0;
        for (int i = 0; i < n && i < exp_log.size(); i++)
            if (load_log[lb + i] !== exp_log[i]) bad++;
        chk("load_order", bad, 0);
        chk("obj_stable", obj_unstable - b_uns, 0);
        bad = 0;
        for (int p = 0; p < 256; p++)
            if (linebuf[p] !== exp_buf[p]) bad++;
        chk("line_pixels", bad, 0);
    endtask

    function automatic obm_object_t mk(input int x, input int y, input int pat,
                                       input int col, input bit hf, input bit vf);
        obm_object_t o;
        o.x = 8'(x); o.y = 8'(y); o.pattern = 5'(pat); o.color = 4'(col);
        o.hflip = hf; o.vflip = vf;
        return o;
    endfunction

    initial begin
        int to, b_clr, b_ld, b_chi, b_lhi, any_busy;
        logic [7:0] ln;
        rst          = 1'b1;
        line_start_i = 1'b0;
        line_y_i     = 8'd0;
        for (int i = 0; i < N; i++) obm[i] = mk(0, 100, 0, 0, 0, 0);
        for (int p = 0; p < 256; p++) patmem[p] = 16'h0000;
        repeat (3) @(negedge gpu_clk);
        rst = 1'b0;
        @(negedge gpu_clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_clear_start", os_clear_start_o, 0);
        chk("rst_load_start", os_load_start_o, 0);
        chk("rst_new_y", os_new_y_o, 0);
        chk("rst_obm_addr", obm_addr_o, 0);
        chk("rst_load_object", os_load_object_o, 0);
        chk("rst_pattern_addr", pattern_addr_o, 0);

        // No object covers line 20
        run_line(8'd20, 1'b1);
        chk("t1_no_loads", load_cnt - lb, 0);

        // Single object, upright then flipped
        obm[3] = mk(40, 16, 9, 1, 0, 0);
        patmem[9 * 8 + 4] = 16'h1B1B;
        patmem[9 * 8 + 3] = 16'hE4C6;
        run_line(8'd20, 1'b0);
        chk("t2_px40_transparent", linebuf[40], 0);
        chk("t2_px41", linebuf[41], 1);
        chk("t2_px43", linebuf[43], 3);
        chk("t2_px47", linebuf[47], 3);
        obm[3] = mk(40, 16, 9, 1, 1, 1);
        run_line(8'd20, 1'b0);
        chk("t3_row_addr", first_paddr, 8'h4B);
        chk("t3_px40", linebuf[40], 2);
        chk("t3_px42_transparent", linebuf[42], 0);
        chk("t3_px47", linebuf[47], 3);

        // Overlap: lower index is painted last
        obm[3] = mk(0, 100, 0, 0, 0, 0);
        obm[5] = mk(10, 20, 1, 2, 0, 0);
        obm[0] = mk(10, 20, 2, 5, 0, 0);
        patmem[1 * 8] = 16'hFFFF;
        patmem[2 * 8] = 16'h5555;
        run_line(8'd20, 1'b0);
        chk("t4_first_color", load_log[lb].color, 2);
        chk("t4_second_color", load_log[lb + 1].color, 5);
        chk("t4_px10", linebuf[10], 1);

        // Bottom-of-screen boundaries
        for (int i = 0; i < N; i++) obm[i] = mk(0, 100, 0, 0, 0, 0);
        obm[7] = mk(0, 252, 3, 0, 0, 0);
        patmem[3 * 8 + 6] = 16'hFFFF;
        run_line(8'd2, 1'b0);
        chk("t5_no_wrap", load_cnt - lb, 0);
        obm[7] = mk(200, 248, 3, 0, 0, 0);
        patmem[3 * 8 + 7] = 16'hAAAA;
        run_line(8'd255, 1'b0);
        chk("t5_bottom_load", load_cnt - lb, 1);
        chk("t5_px200", linebuf[200], 2);

        // Abort mid-walk, then reset mid-clear
        obm[12] = mk(30, 18, 1, 0, 0, 0);
        obm[8]  = mk(60, 18, 2, 0, 0, 0);
        obm[4]  = mk(90, 18, 1, 0, 0, 0);
        b_ld = load_cnt; b_clr = clear_cnt;
        @(negedge gpu_clk);
        line_y_i = 8'd20; line_start_i = 1'b1;
        @(negedge gpu_clk);
        line_start_i = 1'b0;
        to = 0;
        while (load_cnt == b_ld && to < 5000) begin @(negedge gpu_clk); to++; end
        chk("ab_load_seen", load_cnt - b_ld, 1);
        line_y_i = 8'd7; line_start_i = 1'b1;
        @(negedge gpu_clk);
        line_start_i = 1'b0;
        to = 0;
        while (clear_cnt < b_clr + 2 && to < 5000) begin @(negedge gpu_clk); to++; end
        chk("ab_reclear", clear_cnt - b_clr, 2);
        chk("ab_clear_y", clear_y, 8'd7);
        repeat (20) @(negedge gpu_clk);
        rst = 1'b1;
        @(negedge gpu_clk);
        rst = 1'b0;
        chk("ab_rst_busy", busy_o, 0);
        chk("ab_rst_done", done_o, 0);
        chk("ab_rst_clear_start", os_clear_start_o, 0);
        chk("ab_rst_load_start", os_load_start_o, 0);
        chk("ab_rst_new_y", os_new_y_o, 0);
        chk("ab_rst_obm_addr", obm_addr_o, 0);
        chk("ab_rst_load_object", os_load_object_o, 0);
        b_chi = clr_hi; b_lhi = ld_hi; any_busy = 0;
        repeat (400) begin
            @(negedge gpu_clk);
            if (busy_o !== 1'b0) any_busy++;
        end
        chk("ab_quiet_clear", clr_hi - b_chi, 0);
        chk("ab_quiet_load", ld_hi - b_lhi, 0);
        chk("ab_quiet_busy", any_busy, 0);
        run_line(8'd20, 1'b0);

        // Randomised lines against the reference
        for (int p = 0; p < 256; p++) patmem[p] = 16'($urandom);
        for (int it = 0; it < 6; it++) begin
            ln = 8'($urandom_range(0, 255));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0)
                    obm[i] = mk($urandom_range(0, 255), $urandom_range(0, 255),
                                $urandom_range(0, 31), $urandom_range(0, 15),
                                1'($urandom), 1'($urandom));
                else
                    obm[i] = mk($urandom_range(0, 255), (int'(ln) - $urandom_range(0, 10)) & 255,
                                $urandom_range(0, 31), $urandom_range(0, 15),
                                1'($urandom), 1'($urandom));
            end
            run_line(ln, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
